ex_alu_iter: RTL and testbench
==============================

Name: ex_alu_iter

Overview:
- Execute-stage ALU sitting directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus two operands and produces a registered result.
- ADD/SUB/AND/OR complete in one cycle. MUL runs on an iterative radix-2 shift-add datapath.
- Raises a stall to the hazard/pipeline-register logic while a multiply is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- valid_i  in  1  operation request present this cycle.
- ALUCtrl_i  in  4  operation code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0100 MUL.
- data1_i  in  WIDTH  operand A (rs1 side).
- data2_i  in  WIDTH  operand B (rs2/immediate side).
- ready_o  out  1  block can accept a request this cycle.
- stall_o  out  1  freeze upstream pipeline registers.
- valid_o  out  1  one-cycle pulse: data_o/Zero_o hold a new result.
- data_o  out  WIDTH  result, registered.
- Zero_o  out  1  data_o == 0, registered alongside data_o.

Behaviour:
- Reset (rst_i=0 at clock edge): state=IDLE, counter=0, valid_o=0, data_o=0, Zero_o=1, internal accumulator/multiplicand/multiplier cleared.
- Reset mid-multiply aborts the operation; no valid_o pulse follows.
- States: IDLE, MUL_BUSY, MUL_DONE.
- ready_o = (state==IDLE).
- Inputs are ignored whenever ready_o=0.
- IDLE, valid_i=1, non-MUL code:
  - Result computed combinationally and registered at the next edge.
  - valid_o=1 for exactly that following cycle (latency 1).
  - State stays IDLE, so back-to-back single-cycle ops are accepted every cycle.
- Arithmetic: ADD/SUB are modulo 2^WIDTH; no overflow flag; SUB = A + ~B + 1.
- Unknown ALUCtrl_i code: result 0, Zero_o=1, valid_o still pulses.
- IDLE, valid_i=1, MUL:
  - Capture mcand=A, mplier=B, acc=0, counter=0.
  - Go to MUL_BUSY; valid_o stays 0.
- MUL_BUSY, each cycle:
  - If mplier[0]: acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, counter++.
  - When counter reaches WIDTH-1 (the WIDTH-th iteration), go to MUL_DONE.
  - Early termination is not permitted; latency is fixed.
- MUL_DONE: data_o = acc (low WIDTH bits of the product; signed and unsigned low halves are identical), Zero_o updated, valid_o=1 for one cycle, return to IDLE.
- MUL latency: request at cycle T gives valid_o at cycle T+WIDTH+1 (T+33 for WIDTH=32). The next request is accepted at T+WIDTH+1 at the earliest.
- stall_o = (state!=IDLE) | (state==IDLE & valid_i & ALUCtrl_i==MUL).
  - Combinational; asserted in the accept cycle so upstream holds the MUL instruction's successors.
  - Deasserted in the MUL_DONE cycle's successor IDLE.
- valid_o is 0 in every cycle not listed above. data_o/Zero_o hold their last value between pulses.

Decomposition:
- Shared package: ALU control code constants (ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_MUL=4'b0100), the same constants the ALU control decoder uses. Also the state encoding localparams.
- One sub-module: alu_mul_iter, containing the shift-add datapath plus counter with start/done handshake. The top holds the single-cycle ops, the FSM and the output registers.

Test Plan:
- Reset: hold rst_i=0 two cycles with valid_i=1 -> valid_o=0, data_o=0, Zero_o=1, ready_o=1 and stall_o=0 after release.
- Back-to-back single-cycle ops on consecutive cycles:
  - ADD 7+5, then SUB 5-7, then AND F0F0_F0F0&0FF0_0FF0, then OR.
  - Expect valid_o high 4 consecutive cycles with 12, FFFF_FFFE, 00F0_00F0, 0xFFF0_FFF0 (OR of the same operands).
  - stall_o stays 0 throughout.
- Wrap and zero: ADD FFFF_FFFF+1 -> data_o=0, Zero_o=1. SUB 3-3 -> 0, Zero_o=1.
- MUL 0x0001_0003 * 0x0000_0005 at cycle T:
  - stall_o=1 from T through T+32, ready_o=0 from T+1.
  - valid_o only at T+33 with 0x0005_000F.
  - ADD presented during the busy window is ignored.
- MUL sign/overflow: FFFF_FFFF*FFFF_FFFF -> 0000_0001. 8000_0000*2 -> 0, Zero_o=1.
- Reset at T+10 of a MUL -> no valid_o pulse, IDLE next cycle, a following ADD 1+1 returns 2 with latency 1.

Source files
------------

// File: rtl/ex_alu_iter_pkg.sv
// rtl/ex_alu_iter_pkg.sv - shared ALU control codes and FSM state encoding
//
// Purpose: constants shared with the ALU control decoder, the state encoding
//          of the execute ALU FSM, and a small decode helper.
// Ports:   none (package).
package ex_alu_iter_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0100;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_BUSY = 2'd1;
    localparam logic [1:0] ST_MUL_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        MUL_BUSY = ST_MUL_BUSY,
        MUL_DONE = ST_MUL_DONE
    } state_e;

    function automatic logic is_mul(input logic [3:0] ctrl);
        return ctrl == ALU_MUL;
    endfunction

endpackage

// File: rtl/ex_alu_iter_if.sv
// rtl/ex_alu_iter_if.sv - request/result bundle between pipeline and execute ALU
//
// Purpose: groups the operation request and result signals of ex_alu_iter.
// Ports:   valid_i/ALUCtrl_i/data1_i/data2_i (request, pipeline -> ALU),
//          ready_o/stall_o/valid_o/data_o/Zero_o (status and result, ALU -> pipeline).
//          master = pipeline side, slave = ALU side.
interface ex_alu_iter_if #(
    parameter int WIDTH = 32
) ();
    logic             valid_i;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             ready_o;
    logic             stall_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             Zero_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  ready_o, stall_o, valid_o, data_o, Zero_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output ready_o, stall_o, valid_o, data_o, Zero_o
    );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative radix-2 shift-add multiplier datapath
//
// Purpose: low WIDTH bits of mcand*mplier, one partial product per cycle,
//          exactly WIDTH iterations after start (no early exit).
// Ports:   clk_i, rst_i (sync, active-low), start_i (load operands),
//          mcand_i/mplier_i (operands), near_done_o (next cycle is the
//          last iteration), product_o (accumulator after the current iteration).
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             near_done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // The top registers product_o during the final iteration, so the result
    // lands in the output register on the same edge the accumulator would.
    assign near_done_o = run_q && (cnt_q == CNT_PEN);
    assign product_o   = acc_next;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

// File: rtl/ex_alu_iter.sv
// rtl/ex_alu_iter.sv - execute-stage ALU with single-cycle ops and iterative MUL
//
// Purpose: ADD/SUB/AND/OR with latency 1; MUL through alu_mul_iter with
//          latency WIDTH+1 while stalling the upstream pipeline.
// Ports:   clk_i, rst_i (sync, active-low), bus (ex_alu_iter_if.slave):
//          request valid_i/ALUCtrl_i/data1_i/data2_i, status ready_o/stall_o,
//          registered result valid_o/data_o/Zero_o.
module ex_alu_iter
    import ex_alu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ex_alu_iter_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;
    logic             mul_start;
    logic             mul_near_done;
    logic [WIDTH-1:0] mul_product;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (mul_start),
        .mcand_i     (bus.data1_i),
        .mplier_i    (bus.data2_i),
        .near_done_o (mul_near_done),
        .product_o   (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        mul_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    if (is_mul(bus.ALUCtrl_i)) begin
                        mul_start = 1'b1;
                        state_d   = MUL_BUSY;
                    end else begin
                        valid_d = 1'b1;
                        case (bus.ALUCtrl_i)
                            ALU_ADD: data_d = bus.data1_i + bus.data2_i;
                            ALU_SUB: data_d = bus.data1_i + ~bus.data2_i + WIDTH'(1);
                            ALU_AND: data_d = bus.data1_i & bus.data2_i;
                            ALU_OR:  data_d = bus.data1_i | bus.data2_i;
                            default: data_d = '0;
                        endcase
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_near_done) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                // Datapath is in its final iteration here.
                data_d  = mul_product;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        zero_d = (data_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.stall_o = (state_q != IDLE)
                       | ((state_q == IDLE) & bus.valid_i & is_mul(bus.ALUCtrl_i));
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.Zero_o  = zero_q;
endmodule

// File: tb/tb_ex_alu_iter.sv
// tb/tb_ex_alu_iter.sv - scoreboard testbench for ex_alu_iter
module tb_ex_alu_iter;
    import ex_alu_iter_pkg::*;

    localparam int W = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    ex_alu_iter_if #(.WIDTH(W)) bus ();

    ex_alu_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [63:0] p;
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0100: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
            default: return '0;
        endcase
    endfunction

    // Scoreboard monitor: every valid_o pulse must match the oldest expectation
    // in both value and cycle; an expectation whose cycle passes is missed.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].c < cyc) begin
                chk("missed_valid", 32'(cyc), 32'(sb[0].c));
                void'(sb.pop_front());
            end
            if (bus.valid_o === 1'b1) begin
                if (sb.size() == 0 || sb[0].c != cyc) begin
                    chk("unexpected_valid", 32'(cyc), (sb.size() == 0) ? 32'hFFFF_FFFF : 32'(sb[0].c));
                end else begin
                    chk("data_o", bus.data_o, sb[0].d);
                    chk("Zero_o", 32'(bus.Zero_o), 32'(sb[0].d == '0));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(posedge clk_i);
        #1;
        bus.valid_i   = v;
        bus.ALUCtrl_i = c;
        bus.data1_i   = a;
        bus.data2_i   = b;
    endtask

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        drive(1'b1, c, a, b);
        e.d = model(c, a, b);
        e.c = cyc + ((c == ALU_MUL) ? W + 1 : 1);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, ALU_ADD, '0, '0);
    endtask

    // MUL with cycle-by-cycle status checks; junk requests during busy are ignored.
    task automatic mul_window(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(ALU_MUL, a, b);
        @(negedge clk_i);
        chk("stall_accept", 32'(bus.stall_o), 32'd1);
        chk("ready_accept", 32'(bus.ready_o), 32'd1);
        for (int k = 1; k <= W; k++) begin
            drive(1'($urandom_range(0, 1)), (k == 5) ? ALU_ADD : 4'($urandom), $urandom, $urandom);
            @(negedge clk_i);
            chk($sformatf("stall_busy_%0d", k), 32'(bus.stall_o), 32'd1);
            chk($sformatf("ready_busy_%0d", k), 32'(bus.ready_o), 32'd0);
        end
        drive(1'b0, ALU_ADD, '0, '0);
        @(negedge clk_i);
        chk("stall_after", 32'(bus.stall_o), 32'd0);
        chk("ready_after", 32'(bus.ready_o), 32'd1);
    endtask

    initial begin
        logic [3:0] ops [6];
        logic [3:0] c;
        int         t;
        ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND;
        ops[3] = ALU_OR;  ops[4] = ALU_MUL; ops[5] = 4'b1011;

        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ALU_ADD;
        bus.data1_i   = 32'd3;
        bus.data2_i   = 32'd4;
        rst_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b1;
        bus.valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst_data_o", bus.data_o, 32'd0);
        chk("rst_Zero_o", 32'(bus.Zero_o), 32'd1);
        chk("rst_ready_o", 32'(bus.ready_o), 32'd1);
        chk("rst_stall_o", 32'(bus.stall_o), 32'd0);
        mon_en = 1'b1;

        // Back-to-back single-cycle ops with stall monitored each cycle.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: issue(ALU_ADD, 32'd7, 32'd5);
                1: issue(ALU_SUB, 32'd5, 32'd7);
                2: issue(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
                default: issue(ALU_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
            endcase
            @(negedge clk_i);
            chk("b2b_stall", 32'(bus.stall_o), 32'd0);
        end
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        issue(ALU_SUB, 32'd3, 32'd3);
        issue(4'b1111, 32'h1234_5678, 32'h1);
        idle(2);

        mul_window(32'h0001_0003, 32'h0000_0005);
        mul_window(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mul_window(32'h8000_0000, 32'h0000_0002);
        idle(2);

        // Reset in the middle of a multiply: no pulse, IDLE immediately after.
        issue(ALU_MUL, 32'd1234, 32'd5678);
        t = cyc;
        idle(9);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_cycle", 32'(cyc - t), 32'd11);
        chk("abort_ready", 32'(bus.ready_o), 32'd1);
        chk("abort_stall", 32'(bus.stall_o), 32'd0);
        chk("abort_data", bus.data_o, 32'd0);
        issue(ALU_ADD, 32'd1, 32'd1);
        idle(2);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            c = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, c, $urandom, $urandom);
            end else begin
                issue(c, ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom), 32'($urandom));
                if (c == ALU_MUL) begin
                    for (int k = 0; k < W; k++)
                        drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
                end
            end
        end

        t = 0;
        while (sb.size() > 0 && t < 100) begin
            idle(1);
            t++;
        end
        idle(2);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
